block_renderer: RTL and testbench
=================================

Name: block_renderer

Overview:
- Consumer side of the game-logic coordinate interface.
- Takes the current block position (x, y) and a draw request from the game logic.
- Erases the previously drawn block, then rasterises the new block into the VGA adapter pixel-write port, one pixel per clock.
- Also supports a full-screen clear for game restart.

Parameters:
- BLK_W, 16, block width in pixels (1..64)
- BLK_H, 4, block height in pixels (1..16)
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped
- BG_COLOUR, 3'b000, colour used for erase and clear

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- resetn  input  1  asynchronous, active-low reset
- draw_req  input  1  single-cycle request to draw a block at x_in/y_in
- clr_req  input  1  single-cycle request to fill the whole screen with BG_COLOUR
- x_in  input  8  block top-left x, from game logic
- y_in  input  7  block top-left y, from game logic
- colour_in  input  3  block colour
- busy  output  1  high while any operation is in progress
- done  output  1  one-cycle pulse when an operation completes
- vga_x  output  8  pixel x to the VGA adapter
- vga_y  output  7  pixel y to the VGA adapter
- vga_colour  output  3  pixel colour
- vga_plot  output  1  pixel write enable

Behaviour:
- Reset (async, resetn=0): state IDLE; busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0; prev_valid=0; all counters 0. Reset asserted mid-operation aborts immediately; no further plots occur.
- States: IDLE, ERASE, DRAW, CLEAR, FIN.
- IDLE, clr_req=1: go to CLEAR. clr_req has priority over a simultaneous draw_req, which is dropped.
- IDLE, draw_req=1: latch x_in, y_in, colour_in. If prev_valid, go to ERASE; otherwise go to DRAW.
- ERASE: raster over BLK_W x BLK_H at the stored prev_x/prev_y in colour BG_COLOUR, then go to DRAW.
- DRAW: raster over BLK_W x BLK_H at the latched position in the latched colour. On the last pixel, set prev_x/prev_y to the latched values, set prev_valid=1, go to FIN.
- CLEAR: raster over SCREEN_W x SCREEN_H from (0,0) in BG_COLOUR. On the last pixel, clear prev_valid and go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Raster order: column counter is inner (0..W-1), row counter is outer (0..H-1). One pixel per cycle, no gaps.
- Output registers: vga_x = base_x + col and vga_y = base_y + row, both computed at 9 bits.
  - vga_plot=1 only when the 9-bit sums are < SCREEN_W and < SCREEN_H.
  - Clipped pixels still consume their cycle with vga_plot=0; vga_x/vga_y carry the truncated low bits.
- Latency (draw with prev_valid=0):
  - Request sampled at edge 0; first vga_plot at edge 1, with vga_x=x_in, vga_y=y_in.
  - Last pixel at edge BLK_W*BLK_H.
  - done high in the following cycle.
  - Total busy time: BLK_W*BLK_H+1 cycles.
- Latency (draw with prev_valid=1): add BLK_W*BLK_H cycles for the erase pass.
- busy goes high the cycle after the accepted request and is low again in the cycle after done.
- draw_req or clr_req arriving while busy=1 is ignored, not queued.
- x_in, y_in and colour_in are sampled only on the accepted request; later changes do not affect an operation in progress.
- vga_plot=0 in IDLE and FIN.

Optional Feature:
- Macro: BLOCK_RENDERER_OUTLINE_EN.
- When defined: in DRAW, pixels with col==0, col==BLK_W-1, row==0 or row==BLK_H-1 use colour ~colour_in (bitwise invert); interior pixels use colour_in. ERASE and CLEAR are unaffected. Cycle counts are unchanged.
- When undefined: DRAW paints every pixel in colour_in (solid block).

Test Plan:
- Reset then draw_req with x=8'h10, y=7'h20, colour=3'b100 -> 64 consecutive plots from (16,32) to (31,35) in row-major order, all colour 4; done pulses once at cycle 65; busy low afterwards.
- Second draw_req with x=8'h12, y=7'h20 -> first 64 plots erase (16..31, 32..35) in colour 0, next 64 plots draw (18..33, 32..35); done at cycle 129.
- draw_req with x=8'd150, y=7'd118, BLK_W=16, BLK_H=4 -> only x in 150..159 and y in 118..119 have vga_plot=1 (20 plots); total busy duration still 65 cycles.
- draw_req and clr_req in the same cycle -> CLEAR runs: 19200 plots, all colour 0; then prev_valid=0, so the next draw has no erase pass (done at 65).
- draw_req pulsed again 10 cycles into a draw -> ignored, no extra plots; resetn pulsed low at cycle 30 -> vga_plot=0 and busy=0 immediately, and the next draw has no erase pass.
- BLOCK_RENDERER_OUTLINE_EN defined, draw colour=3'b010 -> 36 border pixels in colour 3'b101, 28 interior pixels in colour 3'b010.

Source files
------------

// File: rtl/block_renderer.sv
// rtl/block_renderer.sv - erase/draw/clear block rasteriser feeding the VGA pixel-write port
// Optional feature macro: BLOCK_RENDERER_OUTLINE_EN (block border drawn in inverted colour)
module block_renderer #(
  parameter int unsigned BLK_W     = 16,
  parameter int unsigned BLK_H     = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       draw_req,
  input  logic       clr_req,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [2:0] {IDLE, ERASE, DRAW, CLEAR, FIN} state_t;

  localparam logic [7:0] BLK_W_M1  = 8'(BLK_W - 1);
  localparam logic [6:0] BLK_H_M1  = 7'(BLK_H - 1);
  localparam logic [7:0] SCR_W_M1  = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_H_M1  = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] SCR_H_LIM = 9'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic [7:0] prev_x_q, prev_x_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic       prev_valid_q, prev_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [7:0] col_last;
  logic [6:0] row_last;
  logic [2:0] pix_colour;
  logic       raster;
  logic       last_pix;
  logic [8:0] sum_x;
  logic [8:0] sum_y;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    base_x       = 8'd0;
    base_y       = 7'd0;
    col_last     = BLK_W_M1;
    row_last     = BLK_H_M1;
    pix_colour   = BG_COLOUR;
    raster       = 1'b0;
    last_pix     = 1'b0;

    case (state_q)
      IDLE: begin
        col_d = 8'd0;
        row_d = 7'd0;
        if (clr_req) begin
          state_d = CLEAR;
        end else if (draw_req) begin
          x_d      = x_in;
          y_d      = y_in;
          colour_d = colour_in;
          state_d  = prev_valid_q ? ERASE : DRAW;
        end
      end
      ERASE: begin
        raster = 1'b1;
        base_x = prev_x_q;
        base_y = prev_y_q;
      end
      DRAW: begin
        raster     = 1'b1;
        base_x     = x_q;
        base_y     = y_q;
        pix_colour = colour_q;
`ifdef BLOCK_RENDERER_OUTLINE_EN
        if (col_q == 8'd0 || col_q == BLK_W_M1 || row_q == 7'd0 || row_q == BLK_H_M1)
          pix_colour = ~colour_q;
`endif
      end
      CLEAR: begin
        raster   = 1'b1;
        col_last = SCR_W_M1;
        row_last = SCR_H_M1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Column is the inner counter; the wrap of both marks the final pixel of a pass.
    if (raster) begin
      if (col_q == col_last) begin
        col_d = 8'd0;
        if (row_q == row_last) begin
          row_d    = 7'd0;
          last_pix = 1'b1;
        end else begin
          row_d = row_q + 7'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    if (last_pix) begin
      case (state_q)
        ERASE: state_d = DRAW;
        DRAW: begin
          state_d      = FIN;
          prev_x_d     = x_q;
          prev_y_d     = y_q;
          prev_valid_d = 1'b1;
        end
        CLEAR: begin
          state_d      = FIN;
          prev_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Nine-bit sums so blocks near the right/bottom edge clip instead of wrapping.
  assign sum_x = {1'b0, base_x} + {1'b0, col_q};
  assign sum_y = {2'b00, base_y} + {2'b00, row_q};

  always_comb begin
    vga_plot_d   = raster && (sum_x < SCR_W_LIM) && (sum_y < SCR_H_LIM);
    vga_x_d      = raster ? sum_x[7:0] : vga_x_q;
    vga_y_d      = raster ? sum_y[6:0] : vga_y_q;
    vga_colour_d = raster ? pix_colour : vga_colour_q;
    busy_d       = (state_d != IDLE);
    done_d       = (state_q == FIN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_q        <= 8'd0;
      row_q        <= 7'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      prev_x_q     <= 8'd0;
      prev_y_q     <= 7'd0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_block_renderer.sv
// tb/tb_block_renderer.sv - self-checking bench for block_renderer against a per-cycle expectation queue
module tb_block_renderer;

  logic       clk;
  logic       resetn;
  logic       draw_req;
  logic       clr_req;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  block_renderer #(
    .BLK_W(16), .BLK_H(4), .SCREEN_W(160), .SCREEN_H(120), .BG_COLOUR(3'b000)
  ) dut (
    .clk(clk), .resetn(resetn), .draw_req(draw_req), .clr_req(clr_req),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit busy;
    bit done;
    bit plot;
    bit chk;
    int x;
    int y;
    int c;
  } rec_t;

  rec_t exp_q[$];
  bit   m_prev_valid;
  int   m_px, m_py;

  int vectors;
  int errors;

  int cyc, plot_cnt, busy_cnt, done_cyc;
  int first_x, first_y, last_x, last_y;
  int ccnt [8];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_raster(input int bx, input int by, input int w, input int h,
                             input int c, input bit is_draw);
    for (int r = 0; r < h; r++) begin
      for (int cl = 0; cl < w; cl++) begin
        rec_t e;
        int sx, sy;
        sx = bx + cl;
        sy = by + r;
        e.busy = 1; e.done = 0; e.chk = 1;
        e.plot = (sx < 160) && (sy < 120);
        e.x = sx % 256;
        e.y = sy % 128;
        e.c = c;
`ifdef BLOCK_RENDERER_OUTLINE_EN
        if (is_draw && (cl == 0 || cl == w - 1 || r == 0 || r == h - 1)) e.c = (~c) & 7;
`else
        if (is_draw) e.c = c;
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  // Requests arriving while an operation is still outstanding are dropped.
  task automatic model_req(input bit dr, input bit cr, input int x, input int y, input int c);
    rec_t e;
    if (exp_q.size() != 0 || (!dr && !cr)) return;
    e.busy = 1; e.done = 0; e.plot = 0; e.chk = 0; e.x = 0; e.y = 0; e.c = 0;
    exp_q.push_back(e);
    if (cr) begin
      push_raster(0, 0, 160, 120, 0, 0);
      m_prev_valid = 0;
    end else begin
      if (m_prev_valid) push_raster(m_px, m_py, 16, 4, 0, 0);
      push_raster(x, y, 16, 4, c, 1);
      m_px = x; m_py = y; m_prev_valid = 1;
    end
    e.busy = 0; e.done = 1;
    exp_q.push_back(e);
  endtask

  task automatic clear_stats();
    cyc = -1; plot_cnt = 0; busy_cnt = 0; done_cyc = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int i = 0; i < 8; i++) ccnt[i] = 0;
  endtask

  always @(posedge clk) begin
    rec_t e;
    #1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else begin
      e.busy = 0; e.done = 0; e.plot = 0; e.chk = 0; e.x = 0; e.y = 0; e.c = 0;
    end
    check("busy", int'(busy), int'(e.busy));
    check("done", int'(done), int'(e.done));
    check("vga_plot", int'(vga_plot), int'(e.plot));
    if (e.chk) begin
      check("vga_x", int'(vga_x), e.x);
      check("vga_y", int'(vga_y), e.y);
      if (e.plot) check("vga_colour", int'(vga_colour), e.c);
    end
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cyc = cyc;
    if (vga_plot) begin
      if (plot_cnt == 0) begin first_x = vga_x; first_y = vga_y; end
      last_x = vga_x; last_y = vga_y;
      plot_cnt++;
      ccnt[vga_colour]++;
    end
  end

  task automatic issue(input bit dr, input bit cr, input int x, input int y, input int c);
    @(negedge clk);
    clear_stats();
    draw_req = dr; clr_req = cr;
    x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    model_req(dr, cr, x, y, c);
    @(negedge clk);
    draw_req = 0; clr_req = 0;
    x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", int'(n >= 30000), 0);
  endtask

  initial begin
    vectors = 0; errors = 0; m_prev_valid = 0; m_px = 0; m_py = 0;
    draw_req = 0; clr_req = 0; x_in = 0; y_in = 0; colour_in = 0;
    clear_stats();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // First draw, no previous block to erase.
    issue(1, 0, 8'h10, 7'h20, 3'b100);
    wait_idle();
    check("d1_plots", plot_cnt, 64);
    check("d1_first_x", first_x, 16);
    check("d1_first_y", first_y, 32);
    check("d1_last_x", last_x, 31);
    check("d1_last_y", last_y, 35);
    check("d1_done_cyc", done_cyc, 65);
    check("d1_busy_cycles", busy_cnt, 65);
`ifndef BLOCK_RENDERER_OUTLINE_EN
    check("d1_colour4", ccnt[4], 64);
`endif

    // Second draw erases the first block before drawing.
    issue(1, 0, 8'h12, 7'h20, 3'b100);
    wait_idle();
    check("d2_plots", plot_cnt, 128);
    check("d2_erase_plots", ccnt[0], 64);
    check("d2_first_x", first_x, 16);
    check("d2_last_x", last_x, 33);
    check("d2_last_y", last_y, 35);
    check("d2_done_cyc", done_cyc, 129);

    // Simultaneous clear and draw: clear wins.
    issue(1, 1, 8'h40, 7'h10, 3'b111);
    wait_idle();
    check("clr_plots", plot_cnt, 19200);
    check("clr_bg_plots", ccnt[0], 19200);
    check("clr_done_cyc", done_cyc, 19201);

    // Bottom-right clipping, no erase after clear.
    issue(1, 0, 150, 118, 3'b011);
    wait_idle();
    check("clip_plots", plot_cnt, 20);
    check("clip_busy_cycles", busy_cnt, 65);
    check("clip_done_cyc", done_cyc, 65);
    check("clip_last_x", last_x, 159);
    check("clip_last_y", last_y, 119);

    // Erase of a clipped block followed by a draw at the origin.
    issue(1, 0, 0, 0, 3'b001);
    wait_idle();
    check("org_plots", plot_cnt, 84);
    check("org_done_cyc", done_cyc, 129);

    // Ignored re-request during busy, then reset mid-erase.
    issue(1, 0, 40, 40, 3'b110);
    repeat (8) @(negedge clk);
    draw_req = 1; x_in = 8'd90; y_in = 7'd90; colour_in = 3'b111;
    model_req(1, 0, 90, 90, 7);
    @(negedge clk);
    draw_req = 0;
    repeat (19) @(negedge clk);
    check("abort_plots_before_rst", plot_cnt, 28);
    resetn = 1'b0;
    #1;
    check("abort_plot_async", int'(vga_plot), 0);
    check("abort_busy_async", int'(busy), 0);
    exp_q.delete();
    m_prev_valid = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_more_plots", plot_cnt, 28);

    // Draw after reset has no erase pass.
    issue(1, 0, 8'h10, 7'h20, 3'b010);
    wait_idle();
    check("post_rst_plots", plot_cnt, 64);
    check("post_rst_done_cyc", done_cyc, 65);
`ifdef BLOCK_RENDERER_OUTLINE_EN
    check("outline_border", ccnt[5], 36);
    check("outline_interior", ccnt[2], 28);
`else
    check("solid_colour2", ccnt[2], 64);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
